// File: rtl/daq_rate_step_timer.sv
// Step counter and TX-rate / CDV done handshake conditioner for the DAQ rate-select FSM.
// Optional watchdog timeout is built when DAQ_RATE_WDOG_EN is defined.
module daq_rate_step_timer #(
  parameter int                CNT_W       = 4,
  parameter logic [CNT_W-1:0]  TC_VAL      = 4'd15,
  parameter int                SYNC_STAGES = 2,
  parameter int                WDOG_W      = 12,
  parameter logic [WDOG_W-1:0] WDOG_LIM    = 12'd3000
) (
  input  logic             wrd_clk,
  input  logic             clr_cnt_rst,
  input  logic             INC_CNT,
  input  logic             TXRATEDONE_IN,
  input  logic             CDV_DONE_IN,
  output logic [CNT_W-1:0] CNT,
  output logic             CNT_TC,
  output logic             TXRATEDONE,
  output logic             CDV_DONE,
  output logic             TMO,
  output logic [1:0]       MON_STATE
);

  localparam logic [1:0] S_TXW  = 2'd0;
  localparam logic [1:0] S_CDVW = 2'd1;
  localparam logic [1:0] S_RDY  = 2'd2;
  localparam logic [1:0] S_TMO  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] tx_sync;
  logic [SYNC_STAGES-1:0] cdv_sync;
  logic                   tx_prev;
  logic                   cdv_prev;
  logic                   tx_ev;
  logic                   cdv_ev;
  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic                   txd;
  logic                   txd_nx;
  logic                   cdvd;
  logic                   cdvd_nx;
  logic                   pend;
  logic                   pend_nx;
  logic                   adv;
  logic                   wdog_hit;

  // Saturating step counter
  always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
    if (clr_cnt_rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (INC_CNT && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  // Synchronisers plus a previous-value flop; prev resets low so a level high at release yields one event
  always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
    if (clr_cnt_rst) begin
      tx_sync  <= {SYNC_STAGES{1'b0}};
      cdv_sync <= {SYNC_STAGES{1'b0}};
      tx_prev  <= 1'b0;
      cdv_prev <= 1'b0;
    end else begin
      tx_sync  <= {tx_sync[SYNC_STAGES-2:0], TXRATEDONE_IN};
      cdv_sync <= {cdv_sync[SYNC_STAGES-2:0], CDV_DONE_IN};
      tx_prev  <= tx_sync[SYNC_STAGES-1];
      cdv_prev <= cdv_sync[SYNC_STAGES-1];
    end
  end

  assign tx_ev  = tx_sync[SYNC_STAGES-1] & ~tx_prev;
  assign cdv_ev = cdv_sync[SYNC_STAGES-1] & ~cdv_prev;

  // Handshake sequencing; a CDV event seen before TX is parked in pend so CDV_DONE never precedes TXRATEDONE
  always_comb begin
    state_nx = state;
    txd_nx   = txd;
    cdvd_nx  = cdvd;
    pend_nx  = pend;
    adv      = 1'b0;
    case (state)
      S_TXW: begin
        if (tx_ev) begin
          adv    = 1'b1;
          txd_nx = 1'b1;
          if (pend || cdv_ev) begin
            cdvd_nx  = 1'b1;
            state_nx = S_RDY;
          end else begin
            state_nx = S_CDVW;
          end
        end else if (cdv_ev) begin
          pend_nx = 1'b1;
        end else begin
          pend_nx = pend;
        end
      end
      S_CDVW: begin
        if (cdv_ev) begin
          adv      = 1'b1;
          cdvd_nx  = 1'b1;
          state_nx = S_RDY;
        end else begin
          state_nx = S_CDVW;
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
    if (wdog_hit && !adv) begin
      state_nx = S_TMO;
    end else begin
      state_nx = state_nx;
    end
  end

  // Handshake state and sticky flags
  always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
    if (clr_cnt_rst) begin
      state <= S_TXW;
      txd   <= 1'b0;
      cdvd  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      txd   <= txd_nx;
      cdvd  <= cdvd_nx;
      pend  <= pend_nx;
    end
  end

`ifdef DAQ_RATE_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_LIM - WDOG_ONE;

  logic [WDOG_W-1:0] wdog;
  logic              wdog_run;

  assign wdog_run = (state == S_TXW) || (state == S_CDVW);
  // >= so a limit cycle lost to an advancing event still times out on the next idle cycle
  assign wdog_hit = wdog_run && (wdog >= WDOG_LAST);

  // One watchdog spans both waiting states
  always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
    if (clr_cnt_rst) begin
      wdog <= {WDOG_W{1'b0}};
    end else if (wdog_run) begin
      wdog <= wdog + WDOG_ONE;
    end else begin
      wdog <= wdog;
    end
  end

  assign TMO = (state == S_TMO);
`else
  logic unused_wdog_cfg;

  assign wdog_hit        = 1'b0;
  assign unused_wdog_cfg = ^{WDOG_LIM, adv};
  assign TMO             = 1'b0;
`endif

  assign CNT        = cnt;
  assign CNT_TC     = (cnt == TC_VAL);
  assign TXRATEDONE = txd;
  assign CDV_DONE   = cdvd;
  assign MON_STATE  = state;

endmodule
